// File: rtl/ov7670_pkg.sv
// rtl/ov7670_pkg.sv - shared constants and types for the OV7670 SCCB configurator
package ov7670_pkg;

  localparam int NUM_REGS = 8;

  localparam logic [7:0] REG_COM7  = 8'h12;
  localparam logic [7:0] REG_CLKRC = 8'h11;
  localparam logic [7:0] REG_COM3  = 8'h0C;
  localparam logic [7:0] REG_COM14 = 8'h3E;
  localparam logic [7:0] REG_COM15 = 8'h40;
  localparam logic [7:0] REG_COM17 = 8'h42;

  localparam logic [7:0] DELAY_MARK = 8'hFF;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_BIT,
    S_STOP,
    S_GAP,
    S_DELAY,
    S_NEXT,
    S_FINISH
  } sccb_state_t;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } reg_entry_t;

endpackage

// File: rtl/ov7670_reg_rom.sv
// rtl/ov7670_reg_rom.sv - boot register table: QCIF RGB565, optional colour bars
import ov7670_pkg::*;

module ov7670_reg_rom #(
  parameter int TEST_PATTERN = 0
) (
  input  logic [3:0] index,
  output reg_entry_t entry
);

  always_comb begin
    entry = '{addr: DELAY_MARK, data: 8'h00};
    case (index)
      4'd0: entry = '{addr: REG_COM7,  data: 8'h80};
      4'd1: entry = '{addr: DELAY_MARK, data: 8'h00};
      4'd2: entry = '{addr: REG_COM7,  data: 8'h0C};
      4'd3: entry = '{addr: REG_CLKRC, data: 8'hC0};
      4'd4: entry = '{addr: REG_COM3,  data: 8'h08};
      4'd5: entry = '{addr: REG_COM15, data: 8'hD0};
      4'd6: entry = '{addr: REG_COM14, data: 8'h00};
      4'd7: entry = '{addr: REG_COM17, data: (TEST_PATTERN != 0) ? 8'h08 : 8'h00};
      default: entry = '{addr: DELAY_MARK, data: 8'h00};
    endcase
  end

endmodule

// File: rtl/ov7670_sccb_config.sv
// rtl/ov7670_sccb_config.sv - walks the register table issuing SCCB 3-phase writes
import ov7670_pkg::*;

module ov7670_sccb_config #(
  parameter int         CLK_DIV      = 125,
  parameter logic [7:0] DEV_ID       = 8'h42,
  parameter int         RESET_DELAY  = 50000,
  parameter int         TEST_PATTERN = 0
) (
  input  logic       CLOCK,
  input  logic       RESET_N,
  input  logic       START,
  output logic       SIOC,
  output logic       SIOD_OUT,
  output logic       SIOD_OE,
  output logic       BUSY,
  output logic       DONE,
  output logic [3:0] REG_INDEX
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int DW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DLY_LAST  = DW'(RESET_DELAY - 1);
  localparam logic [3:0]    IDX_LAST  = 4'(NUM_REGS - 1);

  sccb_state_t   state_q, state_d;
  logic [CW-1:0] div_q, div_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [3:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [3:0]    idx_q, idx_d;

  reg_entry_t entry;
  logic       tick;
  logic       bus_phase;
  logic [7:0] cur_byte;
  logic       cur_bit;

  ov7670_reg_rom #(.TEST_PATTERN(TEST_PATTERN)) u_rom (
    .index (idx_q),
    .entry (entry)
  );

  assign tick      = (div_q == TICK_LAST);
  assign bus_phase = (state_q == S_START) || (state_q == S_BIT) ||
                     (state_q == S_STOP)  || (state_q == S_GAP);

  always_comb begin
    cur_byte = entry.data;
    case (byte_q)
      2'd0:    cur_byte = DEV_ID;
      2'd1:    cur_byte = entry.addr;
      default: cur_byte = entry.data;
    endcase
    cur_bit = cur_byte[3'd7 - bit_q[2:0]];
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      dly_q   <= '0;
      qtr_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dly_q   <= dly_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = '0;
    dly_d   = dly_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    idx_d   = idx_q;

    // The divider restarts at every LOAD/NEXT, so each bus phase begins on a full quarter-bit.
    if (bus_phase) begin
      div_d = tick ? '0 : div_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (START) state_d = S_LOAD;
      end
      S_LOAD: begin
        qtr_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
        dly_d   = '0;
        state_d = (entry.addr == DELAY_MARK) ? S_DELAY : S_START;
      end
      S_START: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd1) begin
            qtr_d   = '0;
            state_d = S_BIT;
          end
        end
      end
      S_BIT: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) begin
            if (bit_q == 4'd8) begin
              bit_d  = '0;
              byte_d = byte_q + 2'd1;
              if (byte_q == 2'd2) state_d = S_STOP;
            end else begin
              bit_d = bit_q + 4'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd2) begin
            qtr_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          qtr_d = qtr_q + 2'd1;
          if (qtr_q == 2'd3) state_d = S_NEXT;
        end
      end
      S_DELAY: begin
        if (dly_q == DLY_LAST) state_d = S_NEXT;
        else                   dly_d   = dly_q + 1'b1;
      end
      S_NEXT: begin
        if (idx_q == IDX_LAST) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_FINISH: state_d = S_FINISH;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit 8 of each byte is the released don't-care slot; the pad pull-up supplies the level.
  always_comb begin
    SIOC     = 1'b1;
    SIOD_OUT = 1'b1;
    SIOD_OE  = 1'b1;
    case (state_q)
      S_START: begin
        SIOD_OUT = 1'b0;
        SIOC     = (qtr_q == 2'd0);
      end
      S_BIT: begin
        SIOC = qtr_q[1];
        if (bit_q == 4'd8) SIOD_OE  = 1'b0;
        else               SIOD_OUT = cur_bit;
      end
      S_STOP: begin
        SIOC     = (qtr_q != 2'd0);
        SIOD_OUT = (qtr_q == 2'd2);
      end
      default: ;
    endcase
  end

  assign BUSY      = (state_q != S_IDLE) && (state_q != S_FINISH);
  assign DONE      = (state_q == S_FINISH);
  assign REG_INDEX = idx_q;

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// tb/tb_ov7670_sccb_config.sv - SCCB bus decoder and table model checking two configurator builds
module tb_ov7670_sccb_config;

  localparam int         CLK_DIV     = 2;
  localparam int         RESET_DELAY = 20;
  localparam logic [7:0] DEV_ID      = 8'h42;

  typedef struct packed {
    logic [23:0] bytes;
    logic [31:0] t_start;
    logic [31:0] t_stop;
    logic [31:0] oe_low;
    logic [31:0] oe_bad;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start     [2];
  logic       sioc      [2];
  logic       siod_out  [2];
  logic       siod_oe   [2];
  logic       busy      [2];
  logic       done      [2];
  logic [3:0] reg_index [2];

  always #5 clk = ~clk;

  ov7670_sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ID(DEV_ID), .RESET_DELAY(RESET_DELAY), .TEST_PATTERN(0)) dut0 (
    .CLOCK(clk), .RESET_N(rst_n), .START(start[0]), .SIOC(sioc[0]), .SIOD_OUT(siod_out[0]),
    .SIOD_OE(siod_oe[0]), .BUSY(busy[0]), .DONE(done[0]), .REG_INDEX(reg_index[0])
  );

  ov7670_sccb_config #(.CLK_DIV(CLK_DIV), .DEV_ID(DEV_ID), .RESET_DELAY(RESET_DELAY), .TEST_PATTERN(1)) dut1 (
    .CLOCK(clk), .RESET_N(rst_n), .START(start[1]), .SIOC(sioc[1]), .SIOD_OUT(siod_out[1]),
    .SIOD_OE(siod_oe[1]), .BUSY(busy[1]), .DONE(done[1]), .REG_INDEX(reg_index[1])
  );

  int n_cmp  = 0;
  int n_fail = 0;

  int          cyc;
  logic        p_sioc [2], p_line [2], p_done [2], p_busy [2], line_v [2];
  bit          in_txn [2];
  int          nrise [2], toggles [2], glitch [2], done_rise [2], done_err [2], oe_out [2];
  int          t_st [2], oe_low [2], oe_bad [2];
  logic [3:0]  idx_done [2];
  logic [26:0] bits [2];
  logic [23:0] dec_b;
  txn_t        rec;
  txn_t        tq0 [$];
  txn_t        tq1 [$];
  logic [23:0] exp_q [$];

  // Bus-level decoder: start/stop from SIOD edges while SIOC is high, data sampled on SIOC rise.
  initial begin
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      p_sioc[m] = 1'b1; p_line[m] = 1'b1; p_done[m] = 1'b0; p_busy[m] = 1'b0;
      in_txn[m] = 1'b0; nrise[m] = 0; toggles[m] = 0; glitch[m] = 0;
      done_rise[m] = 0; done_err[m] = 0; oe_out[m] = 0; idx_done[m] = '0;
      t_st[m] = 0; oe_low[m] = 0; oe_bad[m] = 0; bits[m] = '0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int m = 0; m < 2; m++) begin
        line_v[m] = siod_oe[m] ? siod_out[m] : 1'b1;
        if (!rst_n) begin
          in_txn[m] = 1'b0;
          nrise[m]  = 0;
        end else begin
          if (sioc[m] !== p_sioc[m]) toggles[m]++;
          if (p_sioc[m] && sioc[m] && (line_v[m] !== p_line[m])) begin
            if (!line_v[m] && !in_txn[m]) begin
              in_txn[m] = 1'b1; nrise[m] = 0; t_st[m] = cyc; oe_low[m] = 0; oe_bad[m] = 0;
            end else if (line_v[m] && in_txn[m] && nrise[m] == 28) begin
              for (int k = 0; k < 3; k++)
                for (int j = 0; j < 8; j++)
                  dec_b[8*(2-k) + 7 - j] = bits[m][9*k + j];
              rec.bytes   = dec_b;
              rec.t_start = t_st[m];
              rec.t_stop  = cyc;
              rec.oe_low  = oe_low[m];
              rec.oe_bad  = oe_bad[m];
              if (m == 0) tq0.push_back(rec);
              else        tq1.push_back(rec);
              in_txn[m] = 1'b0;
            end else begin
              glitch[m]++;
            end
          end else if (in_txn[m] && !p_sioc[m] && sioc[m]) begin
            if (nrise[m] < 27) begin
              bits[m][nrise[m]] = line_v[m];
              if (siod_oe[m] !== ((nrise[m] % 9) != 8)) oe_bad[m]++;
            end
            nrise[m]++;
          end
          if (!siod_oe[m]) begin
            if (in_txn[m]) oe_low[m]++;
            else           oe_out[m]++;
          end
          if (done[m] && !p_done[m]) begin
            done_rise[m]++;
            idx_done[m] = reg_index[m];
            if (busy[m] !== 1'b0 || p_busy[m] !== 1'b1) done_err[m]++;
          end
        end
        p_sioc[m] = sioc[m]; p_line[m] = line_v[m]; p_done[m] = done[m]; p_busy[m] = busy[m];
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_ge(input string tag, input longint obs, input longint min_v);
    n_cmp++;
    assert (obs >= min_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected at least %0d", tag, obs, min_v);
    end
  endtask

  // Expected traffic: every table entry except the delay marker becomes {ID, addr, data}.
  task automatic build_model(input bit tp);
    logic [15:0] tbl [8];
    tbl = '{16'h1280, 16'hFF00, 16'h120C, 16'h11C0, 16'h0C08, 16'h40D0, 16'h3E00,
            tp ? 16'h4208 : 16'h4200};
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      if (tbl[i][15:8] != 8'hFF) exp_q.push_back({DEV_ID, tbl[i]});
  endtask

  function automatic txn_t get_txn(input int m, input int i);
    return (m == 0) ? tq0[i] : tq1[i];
  endfunction

  task automatic run_checks(input int m, input int base, input bit tp, input string p);
    txn_t t, t2;
    int   n;
    build_model(tp);
    n = (m == 0) ? tq0.size() : tq1.size();
    check({p, "_write_count"}, 64'(n - base), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < n) begin
        t = get_txn(m, base + k);
        check($sformatf("%s_w%0d_bytes", p, k), 64'(t.bytes), 64'(exp_q[k]));
        check($sformatf("%s_w%0d_oe_low_cycles", p, k), 64'(t.oe_low), 64'(12 * CLK_DIV));
        check($sformatf("%s_w%0d_oe_at_rise_errs", p, k), 64'(t.oe_bad), 64'd0);
      end
    end
    if (n - base == exp_q.size()) begin
      t  = get_txn(m, base);
      t2 = get_txn(m, base + 1);
      check({p, "_start_to_stop"}, 64'(t.t_stop - t.t_start), 64'(112 * CLK_DIV));
      check_ge({p, "_delay_gap"}, longint'(t2.t_start - t.t_stop), longint'(RESET_DELAY + 4 * CLK_DIV));
      for (int k = 1; k < exp_q.size() - 1; k++) begin
        t  = get_txn(m, base + k);
        t2 = get_txn(m, base + k + 1);
        check($sformatf("%s_period%0d", p, k), 64'(t2.t_start - t.t_start), 64'(117 * CLK_DIV + 2));
      end
    end
  endtask

  task automatic wait_done(input int m, input int budget);
    int c = 0;
    while (done[m] !== 1'b1 && c < budget) begin
      @(negedge clk);
      start[m] = ($urandom_range(0, 15) == 0);
      c++;
    end
    start[m] = 1'b0;
    check($sformatf("dut%0d_done_within_budget", m), 64'(done[m]), 64'd1);
  endtask

  task automatic check_bus_reset(input string p, input int m);
    check({p, "_sioc"}, 64'(sioc[m]), 64'd1);
    check({p, "_siod_out"}, 64'(siod_out[m]), 64'd1);
    check({p, "_siod_oe"}, 64'(siod_oe[m]), 64'd1);
    check({p, "_busy"}, 64'(busy[m]), 64'd0);
    check({p, "_done"}, 64'(done[m]), 64'd0);
    check({p, "_reg_index"}, 64'(reg_index[m]), 64'd0);
  endtask

  initial begin
    int base0, dr0, c;
    bit reached;
    rst_n = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    repeat (3) @(negedge clk);
    check_bus_reset("in_reset", 0);
    rst_n = 1'b1;

    repeat (1000) @(negedge clk);
    check("idle_toggles_dut0", 64'(toggles[0]), 64'd0);
    check("idle_toggles_dut1", 64'(toggles[1]), 64'd0);
    check_bus_reset("idle", 0);

    repeat ($urandom_range(1, 40)) @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    check("busy_after_start", 64'(busy[0]), 64'd1);
    repeat ($urandom_range(0, 300)) @(negedge clk);
    wait_done(0, 5000);
    run_checks(0, 0, 1'b0, "tp0");
    check("tp0_done_rises", 64'(done_rise[0]), 64'd1);
    check("tp0_busy_falls_with_done", 64'(done_err[0]), 64'd0);
    check("tp0_index_at_done", 64'(idx_done[0]), 64'd7);
    check("tp0_bad_sioc_high_edges", 64'(glitch[0]), 64'd0);
    check("tp0_oe_low_outside_write", 64'(oe_out[0]), 64'd0);

    repeat (200) begin
      @(negedge clk);
      start[0] = 1'($urandom_range(0, 1));
    end
    start[0] = 1'b0;
    repeat (300) @(negedge clk);
    check("tp0_no_traffic_after_done", 64'(tq0.size()), 64'd7);
    check("tp0_done_sticky", 64'(done[0]), 64'd1);
    check("tp0_busy_after_done", 64'(busy[0]), 64'd0);

    start[1] = 1'b1;
    repeat ($urandom_range(1, 500)) @(negedge clk);
    wait_done(1, 5000);
    run_checks(1, 0, 1'b1, "tp1");
    if (tq1.size() > 0) check("tp1_last_write", 64'(tq1[tq1.size() - 1].bytes), 64'h424208);
    repeat (200) begin
      @(negedge clk);
      start[1] = 1'($urandom_range(0, 1));
    end
    start[1] = 1'b0;
    repeat (300) @(negedge clk);
    check("tp1_no_traffic_after_done", 64'(tq1.size()), 64'd7);
    check("tp1_done_rises", 64'(done_rise[1]), 64'd1);
    check("tp1_bad_sioc_high_edges", 64'(glitch[1]), 64'd0);

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    base0 = tq0.size();
    dr0   = done_rise[0];
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    c = 0;
    reached = 1'b0;
    while (!reached && c < 2000) begin
      @(negedge clk);
      c++;
      reached = (tq0.size() == base0 + 2) && in_txn[0] && (nrise[0] == 12);
    end
    check("reached_byte2_of_write3", 64'(reached), 64'd1);
    check("pre_abort_busy", 64'(busy[0]), 64'd1);
    check("pre_abort_reg_index", 64'(reg_index[0]), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check_bus_reset("async_abort", 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base0 = tq0.size();
    repeat ($urandom_range(1, 40)) @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, 5000);
    run_checks(0, base0, 1'b0, "replay");
    check("replay_done_rises", 64'(done_rise[0] - dr0), 64'd1);
    check("replay_index_at_done", 64'(idx_done[0]), 64'd7);
    check("replay_bad_sioc_high_edges", 64'(glitch[0]), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
